// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag
//   Downstream stage of the 2D DCT. Captures an 8x8 block of signed
//   coefficients on the DCT's transfer strobe, quantizes each coefficient
//   against the JPEG luminance table (reciprocal multiply, sign-magnitude)
//   and streams the results one per cycle in zigzag order on a valid/ready
//   interface toward the entropy coder.
//
//   Build option: define QUANT_ROUND_EN to round half away from zero;
//   otherwise the quotient truncates toward zero.
//
// Ports
//   clock      in   single clock, rising edge
//   reset      in   asynchronous reset, active low
//   y          in   [63:0][IN_W-1:0] coefficient block, n = 8*row + col
//   IN_XFC     in   one-cycle strobe: block on y is valid
//   in_ready   out  idle, next IN_XFC will be accepted (registered)
//   drop       out  one-cycle pulse: IN_XFC arrived while busy, discarded
//   out_data   out  [OUT_W-1:0] quantized coefficient, signed
//   out_index  out  [5:0] natural index of out_data
//   out_last   out  64th beat of the block
//   out_valid  out  out_data/out_index/out_last valid
//   out_ready  in   downstream accepts the beat
module dct_quant_zigzag #(
  parameter int IN_W        = 29,
  parameter int OUT_W       = 12,
  parameter int SCALE_SHIFT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [63:0][IN_W-1:0] y,
  input  logic                  IN_XFC,
  output logic                  in_ready,
  output logic                  drop,
  output logic [OUT_W-1:0]      out_data,
  output logic [5:0]            out_index,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // state   | meaning
  // --------+-----------------------------------------------------------
  // ST_IDLE | waiting for IN_XFC, in_ready = 1
  // ST_RUN  | block captured, streaming 64 zigzag beats then draining
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int S  = 16 + SCALE_SHIFT;
  // Product width: |c| needs IN_W bits (|-2^(IN_W-1)| fits unsigned),
  // reciprocal is 17 bits, plus one bit of headroom for the rounding bias.
  localparam int PW = IN_W + 18;
  localparam logic [PW-1:0] SAT_MAX = PW'((64'd1 << (OUT_W - 1)) - 64'd1);
`ifdef QUANT_ROUND_EN
  localparam logic [PW-1:0] RND_BIAS = PW'(64'd1 << (S - 1));
`endif

  // round(65536 / Q[n]) for the JPEG Annex K luminance table, natural order.
  function automatic logic [16:0] quant_recip(input logic [5:0] n);
    logic [16:0] r;
    r = 17'd0;
    case (n)
      6'd0:  r = 17'd4096;
      6'd1:  r = 17'd5958;
      6'd2:  r = 17'd6554;
      6'd3:  r = 17'd4096;
      6'd4:  r = 17'd2731;
      6'd5:  r = 17'd1638;
      6'd6:  r = 17'd1285;
      6'd7:  r = 17'd1074;
      6'd8:  r = 17'd5461;
      6'd9:  r = 17'd5461;
      6'd10: r = 17'd4681;
      6'd11: r = 17'd3449;
      6'd12: r = 17'd2521;
      6'd13: r = 17'd1130;
      6'd14: r = 17'd1092;
      6'd15: r = 17'd1192;
      6'd16: r = 17'd4681;
      6'd17: r = 17'd5041;
      6'd18: r = 17'd4096;
      6'd19: r = 17'd2731;
      6'd20: r = 17'd1638;
      6'd21: r = 17'd1150;
      6'd22: r = 17'd950;
      6'd23: r = 17'd1170;
      6'd24: r = 17'd4681;
      6'd25: r = 17'd3855;
      6'd26: r = 17'd2979;
      6'd27: r = 17'd2260;
      6'd28: r = 17'd1285;
      6'd29: r = 17'd753;
      6'd30: r = 17'd819;
      6'd31: r = 17'd1057;
      6'd32: r = 17'd3641;
      6'd33: r = 17'd2979;
      6'd34: r = 17'd1771;
      6'd35: r = 17'd1170;
      6'd36: r = 17'd964;
      6'd37: r = 17'd601;
      6'd38: r = 17'd636;
      6'd39: r = 17'd851;
      6'd40: r = 17'd2731;
      6'd41: r = 17'd1872;
      6'd42: r = 17'd1192;
      6'd43: r = 17'd1024;
      6'd44: r = 17'd809;
      6'd45: r = 17'd630;
      6'd46: r = 17'd580;
      6'd47: r = 17'd712;
      6'd48: r = 17'd1337;
      6'd49: r = 17'd1024;
      6'd50: r = 17'd840;
      6'd51: r = 17'd753;
      6'd52: r = 17'd636;
      6'd53: r = 17'd542;
      6'd54: r = 17'd546;
      6'd55: r = 17'd649;
      6'd56: r = 17'd910;
      6'd57: r = 17'd712;
      6'd58: r = 17'd690;
      6'd59: r = 17'd669;
      6'd60: r = 17'd585;
      6'd61: r = 17'd655;
      6'd62: r = 17'd636;
      6'd63: r = 17'd662;
      default: r = 17'd0;
    endcase
    return r;
  endfunction

  // Zigzag position k -> natural index n.
  function automatic logic [5:0] zz_order(input logic [5:0] k);
    logic [5:0] n;
    n = 6'd0;
    case (k)
      6'd0:  n = 6'd0;
      6'd1:  n = 6'd1;
      6'd2:  n = 6'd8;
      6'd3:  n = 6'd16;
      6'd4:  n = 6'd9;
      6'd5:  n = 6'd2;
      6'd6:  n = 6'd3;
      6'd7:  n = 6'd10;
      6'd8:  n = 6'd17;
      6'd9:  n = 6'd24;
      6'd10: n = 6'd32;
      6'd11: n = 6'd25;
      6'd12: n = 6'd18;
      6'd13: n = 6'd11;
      6'd14: n = 6'd4;
      6'd15: n = 6'd5;
      6'd16: n = 6'd12;
      6'd17: n = 6'd19;
      6'd18: n = 6'd26;
      6'd19: n = 6'd33;
      6'd20: n = 6'd40;
      6'd21: n = 6'd48;
      6'd22: n = 6'd41;
      6'd23: n = 6'd34;
      6'd24: n = 6'd27;
      6'd25: n = 6'd20;
      6'd26: n = 6'd13;
      6'd27: n = 6'd6;
      6'd28: n = 6'd7;
      6'd29: n = 6'd14;
      6'd30: n = 6'd21;
      6'd31: n = 6'd28;
      6'd32: n = 6'd35;
      6'd33: n = 6'd42;
      6'd34: n = 6'd49;
      6'd35: n = 6'd56;
      6'd36: n = 6'd57;
      6'd37: n = 6'd50;
      6'd38: n = 6'd43;
      6'd39: n = 6'd36;
      6'd40: n = 6'd29;
      6'd41: n = 6'd22;
      6'd42: n = 6'd15;
      6'd43: n = 6'd23;
      6'd44: n = 6'd30;
      6'd45: n = 6'd37;
      6'd46: n = 6'd44;
      6'd47: n = 6'd51;
      6'd48: n = 6'd58;
      6'd49: n = 6'd59;
      6'd50: n = 6'd52;
      6'd51: n = 6'd45;
      6'd52: n = 6'd38;
      6'd53: n = 6'd31;
      6'd54: n = 6'd39;
      6'd55: n = 6'd46;
      6'd56: n = 6'd53;
      6'd57: n = 6'd60;
      6'd58: n = 6'd61;
      6'd59: n = 6'd54;
      6'd60: n = 6'd47;
      6'd61: n = 6'd55;
      6'd62: n = 6'd62;
      6'd63: n = 6'd63;
      default: n = 6'd0;
    endcase
    return n;
  endfunction

  logic [63:0][IN_W-1:0] buf_q;
  logic [0:0]            state_q, state_d;
  // k counts 0..64; 64 means all beats loaded and the last one is draining.
  logic [6:0]            k_q, k_d;
  logic                  in_ready_q, in_ready_d;
  logic                  drop_q, drop_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [OUT_W-1:0]      out_data_q, out_data_d;
  logic [5:0]            out_index_q, out_index_d;
  logic                  cap_en;
  logic                  load_ok;

  logic [5:0]            zz_n;
  logic [IN_W-1:0]       coef;
  logic                  coef_neg;
  logic [IN_W-1:0]       mag;
  logic [16:0]           recip;
  logic [PW-1:0]         prod, prod_r, qv;
  logic [OUT_W-1:0]      sat_mag, q_val;

  // Quantizer for the coefficient at the current zigzag position.
  always_comb begin
    zz_n     = zz_order(k_q[5:0]);
    coef     = buf_q[zz_n];
    coef_neg = coef[IN_W-1];
    mag      = coef_neg ? (IN_W'(0) - coef) : coef;
    recip    = quant_recip(zz_n);
    prod     = PW'(mag) * PW'(recip);
`ifdef QUANT_ROUND_EN
    prod_r   = prod + RND_BIAS;
`else
    prod_r   = prod;
`endif
    qv       = prod_r >> S;
    // Symmetric clamp so -2^(OUT_W-1) can never appear.
    sat_mag  = (qv > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : qv[OUT_W-1:0];
    q_val    = coef_neg ? (OUT_W'(0) - sat_mag) : sat_mag;
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    drop_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    cap_en      = 1'b0;
    load_ok     = !out_valid_q || out_ready;
    case (state_q)
      ST_IDLE: begin
        if (IN_XFC) begin
          cap_en     = 1'b1;
          k_d        = 7'd0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        // in_ready is 0 for the whole of RUN, including the final handshake.
        drop_d = IN_XFC;
        if (load_ok) begin
          if (k_q != 7'd64) begin
            out_valid_d = 1'b1;
            out_data_d  = q_val;
            out_index_d = zz_n;
            out_last_d  = (k_q == 7'd63);
            k_d         = k_q + 7'd1;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      k_q         <= 7'd0;
      in_ready_q  <= 1'b1;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  // Capture buffer is pure datapath; its contents are only read in RUN.
  always_ff @(posedge clock) begin
    if (cap_en) begin
      buf_q <= y;
    end
  end

  assign in_ready  = in_ready_q;
  assign drop      = drop_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
module tb_dct_quant_zigzag;
  localparam int IN_W        = 29;
  localparam int OUT_W       = 12;
  localparam int SCALE_SHIFT = 3;
  localparam int S           = 16 + SCALE_SHIFT;
  localparam int MAXV        = (1 << (OUT_W - 1)) - 1;
`ifdef QUANT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef logic [63:0][IN_W-1:0] blk_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  blk_t             y = '0;
  logic             IN_XFC = 1'b0;
  logic             in_ready;
  logic             drop;
  logic [OUT_W-1:0] out_data;
  logic [5:0]       out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b1;

  dct_quant_zigzag #(.IN_W(IN_W), .OUT_W(OUT_W), .SCALE_SHIFT(SCALE_SHIFT)) dut (
    .clock(clock), .reset(reset), .y(y), .IN_XFC(IN_XFC),
    .in_ready(in_ready), .drop(drop), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int drop_cnt = 0;

  always @(negedge clock) if (drop === 1'b1) drop_cnt++;

  // JPEG Annex K luminance quantization table, natural order.
  int qtab [64] = '{16, 11, 10, 16, 24, 40, 51, 61,
                    12, 12, 14, 19, 26, 58, 60, 55,
                    14, 13, 16, 24, 40, 57, 69, 56,
                    14, 17, 22, 29, 51, 87, 80, 62,
                    18, 22, 37, 56, 68, 109, 103, 77,
                    24, 35, 55, 64, 81, 104, 113, 92,
                    49, 64, 78, 87, 103, 121, 120, 101,
                    72, 92, 95, 98, 112, 100, 103, 99};
  int zz [64];

  int q_idx[$], q_dat[$], q_cyc[$], st_idx[$], st_dat[$];
  bit q_last[$];
  blk_t junk;

  // Zigzag built by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int p;
    p = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= 0 && (s - r) <= 7; r--) begin
          zz[p] = 8 * r + (s - r); p++;
        end
      end else begin
        for (int r = (s < 8 ? 0 : s - 7); r <= 7 && r <= s; r++) begin
          zz[p] = 8 * r + (s - r); p++;
        end
      end
    end
  endfunction

  function automatic int model_q(input int n, input logic [IN_W-1:0] raw);
    longint c, m, r, p, q;
    c = longint'($signed(raw));
    r = longint'((65536 + qtab[n] / 2) / qtab[n]);
    m = (c < 0) ? -c : c;
    p = m * r;
    if (ROUND) p = p + (longint'(1) <<< (S - 1));
    q = p >>> S;
    if (q > MAXV) q = MAXV;
    return int'((c < 0) ? -q : q);
  endfunction

  task automatic rand_block(output blk_t b);
    int sh, v;
    for (int n = 0; n < 64; n++) begin
      sh = int'($urandom_range(0, IN_W - 2));
      v = int'($urandom_range(0, (32'd1 << sh) - 1));
      if ($urandom_range(0, 1) == 1) v = -v;
      b[n] = IN_W'(v);
      if ($urandom_range(0, 31) == 0) b[n] = {1'b1, {(IN_W-1){1'b0}}};
    end
  endtask

  task automatic send(input blk_t b);
    y = b; IN_XFC = 1'b1;
    @(posedge clock); #1;
    IN_XFC = 1'b0;
  endtask

  // Drains one block into the queues; called 1 time unit after the accept edge.
  task automatic collect(input int stall_at, input int stall_len, input int xfc_at,
                         input bit rand_bp, input int budget);
    int stalled, waited;
    bit pulsed;
    stalled = 0; waited = 0; pulsed = 1'b0;
    q_idx.delete(); q_dat.delete(); q_cyc.delete(); q_last.delete();
    st_idx.delete(); st_dat.delete();
    while (q_idx.size() < 64 && waited < budget) begin
      IN_XFC = 1'b0;
      if (out_valid === 1'b1) begin
        if (q_idx.size() == stall_at && stalled < stall_len) begin
          out_ready = 1'b0;
          st_idx.push_back(int'(out_index));
          st_dat.push_back(int'($signed(out_data)));
          stalled++;
        end else if (rand_bp && $urandom_range(0, 3) == 0) begin
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          if (q_idx.size() == xfc_at && !pulsed) begin
            IN_XFC = 1'b1; y = junk; pulsed = 1'b1;
          end
          q_idx.push_back(int'(out_index));
          q_dat.push_back(int'($signed(out_data)));
          q_last.push_back(out_last);
          q_cyc.push_back(waited);
        end
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clock); #1;
      waited++;
    end
    IN_XFC = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; IN_XFC = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b drop=%b want 1 0 0 0", in_ready, out_valid, out_last, drop);
    end
    tests_run++;
    if (out_data !== '0 || out_index !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got data=%0d idx=%0d want 0 0", out_data, out_index);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_order();
    blk_t b;
    for (int n = 0; n < 64; n++) b[n] = IN_W'(1024);
    send(b);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL order_busy: got in_ready=%b want 0", in_ready);
    end
    collect(-1, 0, -1, 1'b0, 200);
    tests_run++;
    if (q_idx.size() != 64) begin
      tests_failed++; $display("FAIL order_count: got %0d beats want 64", q_idx.size());
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      tests_run++;
      if (q_idx[i] != zz[i] || q_dat[i] != model_q(zz[i], b[zz[i]]) || q_last[i] != (i == 63)) begin
        tests_failed++;
        $display("FAIL order_beat%0d: got idx=%0d data=%0d last=%b want %0d %0d %b",
                 i, q_idx[i], q_dat[i], q_last[i], zz[i], model_q(zz[i], b[zz[i]]), i == 63);
      end
    end
    if (q_idx.size() == 64) begin
      tests_run++;
      if (q_cyc[0] != 1 || q_cyc[63] != 64) begin
        tests_failed++;
        $display("FAIL order_timing: got first=%0d last=%0d want 1 64", q_cyc[0], q_cyc[63]);
      end
      tests_run++;
      if (q_dat[0] != 8 || q_dat[1] != (ROUND ? 12 : 11)) begin
        tests_failed++;
        $display("FAIL order_dc_ac: got %0d %0d want 8 %0d", q_dat[0], q_dat[1], ROUND ? 12 : 11);
      end
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL order_end: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_round();
    blk_t b;
    int v, want;
    for (int t = 0; t < 2; t++) begin
      v = (t == 0) ? 100 : -100;
      want = ROUND ? ((t == 0) ? 1 : -1) : 0;
      b = '0; b[0] = IN_W'(v);
      send(b);
      collect(-1, 0, -1, 1'b0, 200);
      tests_run++;
      if (q_idx.size() != 64 || q_dat[0] != want) begin
        tests_failed++;
        $display("FAIL round_%0d: got beats=%0d dc=%0d want 64 %0d", v, q_idx.size(),
                 (q_dat.size() > 0) ? q_dat[0] : 9999, want);
      end
    end
  endtask

  task automatic test_saturate();
    blk_t b;
    int vals [4] = '{1 << 27, -(1 << 27), -(1 << 28), (1 << 28) - 1};
    int wants [4] = '{2047, -2047, -2047, 2047};
    for (int t = 0; t < 4; t++) begin
      b = '0; b[0] = IN_W'(vals[t]);
      send(b);
      collect(-1, 0, -1, 1'b0, 200);
      tests_run++;
      if (q_idx.size() != 64 || q_dat[0] != wants[t]) begin
        tests_failed++;
        $display("FAIL saturate_%0d: got beats=%0d dc=%0d want 64 %0d", vals[t], q_idx.size(),
                 (q_dat.size() > 0) ? q_dat[0] : 9999, wants[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    blk_t b;
    rand_block(b);
    send(b);
    collect(3, 5, -1, 1'b0, 300);
    tests_run++;
    if (st_idx.size() != 5) begin
      tests_failed++; $display("FAIL bp_stall_len: got %0d want 5", st_idx.size());
    end
    for (int i = 0; i < st_idx.size(); i++) begin
      tests_run++;
      if (st_idx[i] != 16 || st_dat[i] != model_q(16, b[16])) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got idx=%0d data=%0d want 16 %0d", i, st_idx[i], st_dat[i], model_q(16, b[16]));
      end
    end
    tests_run++;
    if (q_idx.size() != 64) begin
      tests_failed++; $display("FAIL bp_count: got %0d want 64", q_idx.size());
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      tests_run++;
      if (q_idx[i] != zz[i] || q_dat[i] != model_q(zz[i], b[zz[i]]) || q_last[i] != (i == 63)) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got idx=%0d data=%0d want %0d %0d", i, q_idx[i], q_dat[i], zz[i], model_q(zz[i], b[zz[i]]));
      end
    end
  endtask

  task automatic test_overlap(input int at);
    blk_t b;
    int d0;
    rand_block(b);
    rand_block(junk);
    send(b);
    d0 = drop_cnt;
    collect(-1, 0, at, 1'b0, 300);
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (drop_cnt - d0 != 1) begin
      tests_failed++; $display("FAIL overlap%0d_drop: got %0d pulses want 1", at, drop_cnt - d0);
    end
    tests_run++;
    if (q_idx.size() != 64 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL overlap%0d_end: got beats=%0d vld=%b rdy=%b want 64 0 1", at, q_idx.size(), out_valid, in_ready);
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      tests_run++;
      if (q_idx[i] != zz[i] || q_dat[i] != model_q(zz[i], b[zz[i]])) begin
        tests_failed++;
        $display("FAIL overlap%0d_beat%0d: got idx=%0d data=%0d want %0d %0d", at, i, q_idx[i], q_dat[i], zz[i], model_q(zz[i], b[zz[i]]));
      end
    end
  endtask

  task automatic test_back_to_back();
    blk_t b1, b2;
    int d0;
    rand_block(b1);
    rand_block(b2);
    d0 = drop_cnt;
    send(b1);
    collect(-1, 0, -1, 1'b0, 200);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_ready: got %b want 1", in_ready);
    end
    send(b2);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_accept: got in_ready=%b want 0", in_ready);
    end
    collect(-1, 0, -1, 1'b0, 200);
    tests_run++;
    if (q_idx.size() != 64 || drop_cnt != d0) begin
      tests_failed++; $display("FAIL b2b_count: got beats=%0d drops=%0d want 64 0", q_idx.size(), drop_cnt - d0);
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      tests_run++;
      if (q_idx[i] != zz[i] || q_dat[i] != model_q(zz[i], b2[zz[i]]) || q_last[i] != (i == 63)) begin
        tests_failed++;
        $display("FAIL b2b_beat%0d: got idx=%0d data=%0d want %0d %0d", i, q_idx[i], q_dat[i], zz[i], model_q(zz[i], b2[zz[i]]));
      end
    end
  endtask

  task automatic test_reset_mid();
    blk_t b;
    int n, w;
    rand_block(b);
    send(b);
    n = 0; w = 0;
    out_ready = 1'b1;
    while (n < 20 && w < 200) begin
      if (out_valid === 1'b1) n++;
      @(posedge clock); #1;
      w++;
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_index !== 6'(zz[20])) begin
      tests_failed++; $display("FAIL rstmid_pre: got vld=%b idx=%0d want 1 %0d", out_valid, out_index, zz[20]);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || out_index !== 6'd0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got vld=%b rdy=%b last=%b idx=%0d want 0 1 0 0", out_valid, in_ready, out_last, out_index);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_random(input int nblk);
    blk_t b;
    for (int t = 0; t < nblk; t++) begin
      rand_block(b);
      send(b);
      collect(-1, 0, -1, 1'b1, 1000);
      tests_run++;
      if (q_idx.size() != 64) begin
        tests_failed++; $display("FAIL rand%0d_count: got %0d want 64", t, q_idx.size());
      end
      for (int i = 0; i < q_idx.size(); i++) begin
        tests_run++;
        if (q_idx[i] != zz[i] || q_dat[i] != model_q(zz[i], b[zz[i]]) || q_last[i] != (i == 63)) begin
          tests_failed++;
          $display("FAIL rand%0d_beat%0d: got idx=%0d data=%0d last=%b want %0d %0d", t, i, q_idx[i], q_dat[i], q_last[i], zz[i], model_q(zz[i], b[zz[i]]));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    build_zz();
    test_reset();
    test_order();
    test_round();
    test_saturate();
    test_backpressure();
    test_overlap(10);
    test_overlap(63);
    test_back_to_back();
    test_reset_mid();
    test_random(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
